// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte/half/word requests into one or two word-granular memory cycles.
// Define MEM_ACCESS_MISALIGNED_EN to split word-crossing accesses; otherwise misaligned requests fail.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 30
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_resp_valid,
    output logic                  o_resp_error,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_mem_enable,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_write_enable,
    output logic [31:0]           o_mem_write_value,
    input  logic [31:0]           i_mem_read_value
);

    typedef enum logic [1:0] {StIdle, StAccess0, StAccess1, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_write;
    logic                  r_unsigned;
    logic                  r_error;
    logic [1:0]            r_size;
    logic [1:0]            r_offset;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata_lo;
    logic [23:0]           r_rdata_hi;

    logic                  w_req_error;
    logic [ADDR_WIDTH-1:0] w_word_addr_inc;
    logic [3:0]            w_base_mask;
    logic [7:0]            w_mask_wide;
    logic [63:0]           w_wdata_wide;
    logic [31:0]           w_read_low;
    logic [31:0]           w_rdata_ext;

`ifdef MEM_ACCESS_MISALIGNED_EN
    logic [2:0] w_bytes;
    logic       w_crossing;

    always_comb begin
        case (r_size)
            2'd0:    w_bytes = 3'd1;
            2'd1:    w_bytes = 3'd2;
            default: w_bytes = 3'd4;
        endcase
    end

    assign w_crossing  = ({1'b0, r_offset} + w_bytes) > 3'd4;
    assign w_req_error = (i_req_size == 2'd3);
`else
    assign w_req_error = (i_req_size == 2'd3)
                       | ((i_req_size == 2'd1) & i_req_addr[0])
                       | ((i_req_size == 2'd2) & (|i_req_addr[1:0]));
`endif

    assign w_word_addr_inc = r_word_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        case (r_size)
            2'd0:    w_base_mask = 4'b0001;
            2'd1:    w_base_mask = 4'b0011;
            default: w_base_mask = 4'b1111;
        endcase
    end

    // Low half of each wide vector feeds the first word, high half the second.
    assign w_mask_wide  = {4'b0000, w_base_mask} << r_offset;
    assign w_wdata_wide = {32'h0, r_wdata} << {r_offset, 3'b000};

    always_comb begin
        case (r_offset)
            2'd0:    w_read_low = r_rdata_lo;
            2'd1:    w_read_low = {r_rdata_hi[7:0],  r_rdata_lo[31:8]};
            2'd2:    w_read_low = {r_rdata_hi[15:0], r_rdata_lo[31:16]};
            default: w_read_low = {r_rdata_hi[23:0], r_rdata_lo[31:24]};
        endcase
    end

    always_comb begin
        case (r_size)
            2'd0:    w_rdata_ext = {{24{~r_unsigned & w_read_low[7]}},  w_read_low[7:0]};
            2'd1:    w_rdata_ext = {{16{~r_unsigned & w_read_low[15]}}, w_read_low[15:0]};
            default: w_rdata_ext = w_read_low;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_state_next = w_req_error ? StDone : StAccess0;
                end
            end
`ifdef MEM_ACCESS_MISALIGNED_EN
            StAccess0: w_state_next = w_crossing ? StAccess1 : StDone;
`else
            StAccess0: w_state_next = StDone;
`endif
            StAccess1: w_state_next = StDone;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready        = 1'b0;
        o_resp_valid       = 1'b0;
        o_resp_error       = 1'b0;
        o_resp_rdata       = 32'h0;
        o_mem_enable       = 1'b0;
        o_mem_addr         = '0;
        o_mem_write_enable = 4'b0000;
        o_mem_write_value  = 32'h0;
        case (r_state)
            StIdle: o_req_ready = 1'b1;
            StAccess0: begin
                o_mem_enable = 1'b1;
                o_mem_addr   = r_word_addr;
                if (r_write) begin
                    o_mem_write_enable = w_mask_wide[3:0];
                    o_mem_write_value  = w_wdata_wide[31:0];
                end
            end
            StAccess1: begin
                o_mem_enable = 1'b1;
                o_mem_addr   = w_word_addr_inc;
                if (r_write) begin
                    o_mem_write_enable = w_mask_wide[7:4];
                    o_mem_write_value  = w_wdata_wide[63:32];
                end
            end
            default: begin
                o_resp_valid = 1'b1;
                o_resp_error = r_error;
                if (!r_write && !r_error) begin
                    o_resp_rdata = w_rdata_ext;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_error     <= 1'b0;
            r_size      <= 2'd0;
            r_offset    <= 2'd0;
            r_word_addr <= '0;
            r_wdata     <= 32'h0;
            r_rdata_lo  <= 32'h0;
            r_rdata_hi  <= 24'h0;
        end else begin
            if (r_state == StIdle && i_req_valid) begin
                r_write     <= i_req_write;
                r_unsigned  <= i_req_unsigned;
                r_error     <= w_req_error;
                r_size      <= i_req_size;
                r_offset    <= i_req_addr[1:0];
                r_word_addr <= i_req_addr[ADDR_WIDTH+1:2];
                r_wdata     <= i_req_wdata;
                r_rdata_lo  <= 32'h0;
                r_rdata_hi  <= 24'h0;
            end
            if (r_state == StAccess0 && !r_write) begin
                r_rdata_lo <= i_mem_read_value;
            end
            // The top byte of the second word can never land in a result.
            if (r_state == StAccess1 && !r_write) begin
                r_rdata_hi <= i_mem_read_value[23:0];
            end
        end
    end

endmodule
